// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the coordinate type used by the VGA raster generator.
package vga_timing_pkg;

    localparam int COORD_W     = 10;
    localparam int COORD_LIMIT = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, plus registered sync and next-state visibility decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter int VISIBLE    = 640
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   advance,
    output coord_t count,
    output coord_t count_next,
    output logic   wrap,
    output logic   sync_n,
    output logic   visible_next
);

    localparam coord_t LAST = coord_t'(TOTAL - 1);

    coord_t count_r;
    coord_t count_next_s;
    logic   wrap_s;
    logic   sync_n_r;
    logic   sync_n_s;
    logic   visible_s;

    // Next position; anything at or beyond the last position returns to zero on an advance
    always_comb begin
        count_next_s = count_r;
        wrap_s       = 1'b0;
        if (advance) begin
            if (count_r >= LAST) begin
                count_next_s = {COORD_W{1'b0}};
                wrap_s       = 1'b1;
            end else begin
                count_next_s = count_r + coord_t'(1'b1);
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Sync and visibility are decoded from the next position so they line up with the count
    always_comb begin
        sync_n_s  = 1'b1;
        visible_s = 1'b0;
        if ((int'(count_next_s) >= SYNC_START) && (int'(count_next_s) < SYNC_START + SYNC_LEN)) begin
            sync_n_s = 1'b0;
        end else begin
            sync_n_s = 1'b1;
        end
        if (int'(count_next_s) < VISIBLE) begin
            visible_s = 1'b1;
        end else begin
            visible_s = 1'b0;
        end
    end

    // Position and sync registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r  <= {COORD_W{1'b0}};
            sync_n_r <= 1'b1;
        end else begin
            count_r  <= count_next_s;
            sync_n_r <= sync_n_s;
        end
    end

    assign count        = count_r;
    assign count_next   = count_next_s;
    assign wrap         = wrap_s;
    assign sync_n       = sync_n_r;
    assign visible_next = visible_s;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: Clk/2 pixel clock, DrawX/DrawY, hs/vs/blank and frame markers.
// Define VGA_FRAME_COUNT_EN to build the completed-frame counter; otherwise frame_count is 0.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic        Clk,
    input  logic        Reset_n,
    output logic        vga_clk,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output coord_t      DrawX,
    output coord_t      DrawY,
    output logic        frame_start,
    output logic        line_end,
    output logic [15:0] frame_count
);

    localparam int     H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int     V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);

    if ((H_TOTAL > COORD_LIMIT) || (V_TOTAL > COORD_LIMIT)) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the 10-bit coordinate range");
    end

    logic   vga_clk_r;
    logic   blank_r;
    logic   frame_start_r;
    logic   line_end_r;
    coord_t x_next_s;
    coord_t y_next_s;
    logic   x_wrap_s;
    logic   y_wrap_s;
    logic   x_vis_s;
    logic   y_vis_s;

    // The counters move on the Clk edge where vga_clk falls, i.e. while vga_clk_r is high
    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .VISIBLE    (H_VISIBLE)
    ) u_h_axis (
        .clk          (Clk),
        .rst_n        (Reset_n),
        .advance      (vga_clk_r),
        .count        (DrawX),
        .count_next   (x_next_s),
        .wrap         (x_wrap_s),
        .sync_n       (hs),
        .visible_next (x_vis_s)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .VISIBLE    (V_VISIBLE)
    ) u_v_axis (
        .clk          (Clk),
        .rst_n        (Reset_n),
        .advance      (x_wrap_s),
        .count        (DrawY),
        .count_next   (y_next_s),
        .wrap         (y_wrap_s),
        .sync_n       (vs),
        .visible_next (y_vis_s)
    );

    // Pixel clock toggle and the frame-level markers, decoded from next coordinates
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vga_clk_r     <= 1'b0;
            blank_r       <= 1'b0;
            frame_start_r <= 1'b1;
            line_end_r    <= 1'b0;
        end else begin
            vga_clk_r     <= ~vga_clk_r;
            blank_r       <= x_vis_s & y_vis_s;
            frame_start_r <= (x_next_s == {COORD_W{1'b0}}) && (y_next_s == {COORD_W{1'b0}});
            line_end_r    <= (x_next_s == H_LAST);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_r;

    // Completed-frame counter, bumped as the vertical axis wraps
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_count_r <= 16'h0000;
        end else if (y_wrap_s) begin
            frame_count_r <= frame_count_r + 16'h0001;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`else
    logic y_wrap_unused_s;
    assign y_wrap_unused_s = y_wrap_s;
    assign frame_count     = 16'h0000;
`endif

    assign vga_clk     = vga_clk_r;
    assign blank       = blank_r;
    assign frame_start = frame_start_r;
    assign line_end    = line_end_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-timing instance for horizontal checks, short-vertical instance for frame checks.
module tb_vga_timing_gen;

    logic        clk_s   = 1'b0;
    logic        rst_n_s = 1'b0;

    logic        d_vga_clk, d_hs, d_vs, d_blank, d_frame_start, d_line_end;
    logic [9:0]  d_DrawX, d_DrawY;
    logic [15:0] d_frame_count;
    logic        s_vga_clk, s_hs, s_vs, s_blank, s_frame_start, s_line_end;
    logic [9:0]  s_DrawX, s_DrawY;
    logic [15:0] s_frame_count;

    int n_tests = 0;
    int n_fail  = 0;
    int pos_bad = 0, sync_bad = 0, blank_bad = 0, mark_bad = 0, fc_bad = 0, clk_bad = 0, stab_bad = 0;
    int hs_low_cnt = 0, hs_min_x = 1023, hs_max_x = 0;
    int vs_low_cnt = 0, vs_min_y = 1023, vs_max_y = 0;
    int s_blank_cnt = 0, d_blank_cnt = 0, fs_cnt = 0, le_cnt = 0;
    int fc_final_exp;

    vga_timing_gen dut_full (
        .Clk(clk_s), .Reset_n(rst_n_s), .vga_clk(d_vga_clk), .hs(d_hs), .vs(d_vs),
        .blank(d_blank), .DrawX(d_DrawX), .DrawY(d_DrawY), .frame_start(d_frame_start),
        .line_end(d_line_end), .frame_count(d_frame_count)
    );

    // Same horizontal timing; 10-line frame (4 visible, vs on lines 6..7)
    vga_timing_gen #(.V_VISIBLE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_short (
        .Clk(clk_s), .Reset_n(rst_n_s), .vga_clk(s_vga_clk), .hs(s_hs), .vs(s_vs),
        .blank(s_blank), .DrawX(s_DrawX), .DrawY(s_DrawY), .frame_start(s_frame_start),
        .line_end(s_line_end), .frame_count(s_frame_count)
    );

    always #10 clk_s = ~clk_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called with vga_clk high and pixel p on the outputs
    task automatic sample_pixel(input int p);
        int   mx, yd, ys;
        logic hs_exp, vsd_exp, vss_exp, bd_exp, bs_exp;
        logic [15:0] fcs_exp;
        mx = p % 800;
        yd = (p / 800) % 525;
        ys = (p / 800) % 10;
        hs_exp  = (mx >= 656 && mx < 752) ? 1'b0 : 1'b1;
        vsd_exp = (yd >= 490 && yd < 492) ? 1'b0 : 1'b1;
        vss_exp = (ys >= 6 && ys < 8) ? 1'b0 : 1'b1;
        bd_exp  = (mx < 640 && yd < 480) ? 1'b1 : 1'b0;
        bs_exp  = (mx < 640 && ys < 4) ? 1'b1 : 1'b0;
`ifdef VGA_FRAME_COUNT_EN
        fcs_exp = 16'(p / 8000);
`else
        fcs_exp = 16'h0000;
`endif
        if (d_vga_clk !== 1'b1 || s_vga_clk !== 1'b1) clk_bad++;
        if (d_DrawX !== 10'(mx) || d_DrawY !== 10'(yd) || s_DrawX !== 10'(mx) || s_DrawY !== 10'(ys)) pos_bad++;
        if (d_hs !== hs_exp || s_hs !== hs_exp || d_vs !== vsd_exp || s_vs !== vss_exp) sync_bad++;
        if (d_blank !== bd_exp || s_blank !== bs_exp) blank_bad++;
        if (d_line_end !== (mx == 799) || s_line_end !== (mx == 799)) mark_bad++;
        if (d_frame_start !== (mx == 0 && yd == 0) || s_frame_start !== (mx == 0 && ys == 0)) mark_bad++;
        if (d_frame_count !== 16'h0000 || s_frame_count !== fcs_exp) fc_bad++;
        if (d_hs === 1'b0) begin
            hs_low_cnt++;
            if (int'(d_DrawX) < hs_min_x) hs_min_x = int'(d_DrawX);
            if (int'(d_DrawX) > hs_max_x) hs_max_x = int'(d_DrawX);
        end
        if (s_vs === 1'b0) begin
            vs_low_cnt++;
            if (int'(s_DrawY) < vs_min_y) vs_min_y = int'(s_DrawY);
            if (int'(s_DrawY) > vs_max_y) vs_max_y = int'(s_DrawY);
        end
        if (s_blank === 1'b1) s_blank_cnt++;
        if (d_blank === 1'b1) d_blank_cnt++;
        if (s_frame_start === 1'b1) fs_cnt++;
        if (d_line_end === 1'b1) le_cnt++;
    endtask

    // Moves from pixel p to p+1: the coordinate changes as vga_clk falls, then holds across its rise
    task automatic step_pixel(input int p);
        @(posedge clk_s); #1;
        if (d_vga_clk !== 1'b0 || s_vga_clk !== 1'b0) clk_bad++;
        if (d_DrawX !== 10'((p + 1) % 800)) stab_bad++;
        @(posedge clk_s); #1;
        if (d_DrawX !== 10'((p + 1) % 800)) stab_bad++;
    endtask

    initial begin
        repeat (3) @(posedge clk_s);
        #1;
        check("rst_vga_clk", d_vga_clk, 0);
        check("rst_hs_vs", {d_hs, d_vs}, 3);
        check("rst_blank", d_blank, 0);
        check("rst_xy", {d_DrawX, d_DrawY}, 0);
        check("rst_line_end", d_line_end, 0);
        check("rst_frame_start", d_frame_start, 1);
        check("rst_frame_count", s_frame_count, 0);

        @(negedge clk_s);
        rst_n_s = 1'b1;
        @(posedge clk_s); #1;
        check("e1_vga_clk", d_vga_clk, 1);
        check("e1_xy", {d_DrawX, d_DrawY}, 0);
        check("e1_blank", d_blank, 1);
        check("e1_frame_start", d_frame_start, 1);
        check("e1_hs_vs", {d_hs, d_vs}, 3);

        for (int p = 0; p < 24000; p++) begin
            sample_pixel(p);
            step_pixel(p);
        end

        check("run_clk_bad", clk_bad, 0);
        check("run_pos_bad", pos_bad, 0);
        check("run_stable_bad", stab_bad, 0);
        check("run_sync_bad", sync_bad, 0);
        check("run_blank_bad", blank_bad, 0);
        check("run_marker_bad", mark_bad, 0);
        check("run_frame_count_bad", fc_bad, 0);
        check("hs_low_count", hs_low_cnt, 30 * 96);
        check("hs_first_x", hs_min_x, 656);
        check("hs_last_x", hs_max_x, 751);
        check("vs_low_count", vs_low_cnt, 3 * 2 * 800);
        check("vs_first_y", vs_min_y, 6);
        check("vs_last_y", vs_max_y, 7);
        check("blank_count_short", s_blank_cnt, 3 * 4 * 640);
        check("blank_count_full", d_blank_cnt, 30 * 640);
        check("frame_start_count", fs_cnt, 3);
        check("line_end_count", le_cnt, 30);

        check("wrap_short_xy", {s_DrawX, s_DrawY}, 0);
        check("wrap_short_frame_start", s_frame_start, 1);
        check("wrap_full_y", d_DrawY, 30);
        check("wrap_full_frame_start", d_frame_start, 0);
`ifdef VGA_FRAME_COUNT_EN
        fc_final_exp = 3;
`else
        fc_final_exp = 0;
`endif
        check("frame_count_3frames", s_frame_count, fc_final_exp);

        for (int p = 24000; p < 24300; p++) step_pixel(p);
        check("pre_reset_x", d_DrawX, 300);
        check("pre_reset_y", d_DrawY, 30);
        check("pre_reset_blank", d_blank, 1);

        #5;
        rst_n_s = 1'b0;
        #1;
        check("async_vga_clk", d_vga_clk, 0);
        check("async_xy", {d_DrawX, d_DrawY}, 0);
        check("async_blank", d_blank, 0);
        check("async_frame_start", d_frame_start, 1);
        check("async_hs_vs_le", {d_hs, d_vs, d_line_end}, 6);
        check("async_frame_count", s_frame_count, 0);

        @(posedge clk_s); #1;
        @(negedge clk_s);
        rst_n_s = 1'b1;
        @(posedge clk_s); #1;
        check("restart_e1_vga_clk", d_vga_clk, 1);
        check("restart_e1_xy", {d_DrawX, d_DrawY}, 0);
        check("restart_e1_blank_fs", {d_blank, d_frame_start}, 3);
        @(posedge clk_s); #1;
        check("restart_e2_vga_clk", d_vga_clk, 0);
        check("restart_e2_x", d_DrawX, 1);
        check("restart_e2_frame_start", d_frame_start, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
